// File: rtl/zl_ts_sync_aligner_pkg.sv
// Shared constants and state encoding for the TS sync aligner and its
// downstream byte stages.
package zl_ts_sync_aligner_pkg;

    localparam int         TS_PKT_LEN     = 188;
    localparam logic [7:0] TS_SYNC_BYTE   = 8'h47;
    localparam int         TS_CONFIRM_CNT = 3;
    localparam int         TS_LOSS_CNT    = 3;

    // Encoding is fixed so that checkers and the core agree on state values.
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } sync_state_t;

endpackage

// File: rtl/zl_byte_out_reg.sv
// Single-entry req/ack output register holding {sop, byte}.
// Handshake: a byte moves downstream on any cycle where out_req && out_ack.
// A new byte may be loaded in the same cycle the held byte drains.
module zl_byte_out_reg
    import zl_ts_sync_aligner_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       load_sop,
    input  logic [7:0] load_data,
    input  logic       out_ack,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_req
);

    // Load has priority over drain; the register holds until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= 8'd0;
            out_sop  <= 1'b0;
            out_req  <= 1'b0;
        end else if (load) begin
            out_data <= load_data;
            out_sop  <= load_sop;
            out_req  <= 1'b1;
        end else if (out_ack) begin
            out_req  <= 1'b0;
        end
    end

endmodule

// File: rtl/zl_ts_sync_aligner.sv
// Finds and tracks 188-byte MPEG-TS packet alignment on the sync byte and
// forwards only packet-aligned bytes to the DVB-S core.
// Handshake (both sides): a byte transfers on a cycle where req && ack.
// In SEARCH/VERIFY input bytes are consumed and discarded; in LOCK the
// input is stalled only when the output register is full and not draining.
module zl_ts_sync_aligner
    import zl_ts_sync_aligner_pkg::*;
#(
    parameter int         PKT_LEN     = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE   = TS_SYNC_BYTE,
    parameter int         CONFIRM_CNT = TS_CONFIRM_CNT,
    parameter int         LOSS_CNT    = TS_LOSS_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_req,
    output logic       data_in_ack,
    output logic [7:0] data_out,
    output logic       data_out_sop,
    output logic       data_out_req,
    input  logic       data_out_ack,
    output logic       locked,
    output logic       sync_err,
    output logic [1:0] dbg_state
);

    sync_state_t state, state_n;
    logic [7:0]  pos, pos_n, pos_inc;
    logic [3:0]  hits, hits_n, miss, miss_n;
    logic        accept, at_boundary, is_sync;
    logic        fwd, fwd_sop, sync_err_n;
    logic        out_room;

    assign out_room    = !data_out_req || data_out_ack;
    assign accept      = data_in_req && data_in_ack;
    assign at_boundary = (pos == 8'd0);
    assign is_sync     = (data_in == SYNC_BYTE);
    assign pos_inc     = (pos == 8'(PKT_LEN - 1)) ? 8'd0 : pos + 8'd1;
    assign dbg_state   = state;

    // Input acceptance: free-running while hunting, flow-controlled when locked.
    // The boundary byte in VERIFY may become the first forwarded byte, so it
    // waits if a byte from a previous lock is still stuck in the output register.
    always_comb begin
        data_in_ack = 1'b1;
        case (state)
            ST_LOCK:   data_in_ack = out_room;
            ST_VERIFY: data_in_ack = !at_boundary || out_room;
            default:   data_in_ack = 1'b1;
        endcase
    end

    // Next-state, position tracking and forwarding decision for each accepted byte.
    always_comb begin
        state_n    = state;
        pos_n      = pos;
        hits_n     = hits;
        miss_n     = miss;
        fwd        = 1'b0;
        fwd_sop    = 1'b0;
        sync_err_n = 1'b0;
        if (accept) begin
            case (state)
                ST_SEARCH: begin
                    if (is_sync) begin
                        state_n = ST_VERIFY;
                        pos_n   = 8'd1;
                        hits_n  = 4'd0;
                    end
                end
                ST_VERIFY: begin
                    pos_n = pos_inc;
                    if (at_boundary) begin
                        if (is_sync) begin
                            hits_n = hits + 4'd1;
                            if (hits + 4'd1 == 4'(CONFIRM_CNT)) begin
                                state_n = ST_LOCK;
                                miss_n  = 4'd0;
                                fwd     = 1'b1;
                                fwd_sop = 1'b1;
                            end
                        end else begin
                            // Failed confirm: the byte is not re-examined as a new sync.
                            state_n = ST_SEARCH;
                            pos_n   = 8'd0;
                            hits_n  = 4'd0;
                        end
                    end
                end
                ST_LOCK: begin
                    pos_n   = pos_inc;
                    fwd     = 1'b1;
                    fwd_sop = at_boundary;
                    if (at_boundary) begin
                        if (is_sync) begin
                            miss_n = 4'd0;
                        end else begin
                            sync_err_n = 1'b1;
                            miss_n     = miss + 4'd1;
                            if (miss + 4'd1 == 4'(LOSS_CNT)) begin
                                // Lock lost: this boundary byte is dropped.
                                fwd     = 1'b0;
                                fwd_sop = 1'b0;
                                state_n = ST_SEARCH;
                                pos_n   = 8'd0;
                                miss_n  = 4'd0;
                            end
                        end
                    end
                end
                default: begin
                    state_n = ST_SEARCH;
                    pos_n   = 8'd0;
                end
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_SEARCH;
            pos      <= 8'd0;
            hits     <= 4'd0;
            miss     <= 4'd0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            hits     <= hits_n;
            miss     <= miss_n;
            locked   <= (state_n == ST_LOCK);
            sync_err <= sync_err_n;
        end
    end

    zl_byte_out_reg u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && fwd),
        .load_sop  (fwd_sop),
        .load_data (data_in),
        .out_ack   (data_out_ack),
        .out_data  (data_out),
        .out_sop   (data_out_sop),
        .out_req   (data_out_req)
    );

endmodule

// File: tb/tb_zl_ts_sync_aligner.sv
// Directed bench for the TS sync aligner: the stimulus side pushes every
// byte that should reach data_out as {sop, byte}; a negedge monitor pops
// and compares on each output transfer.
module tb_zl_ts_sync_aligner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       data_in_req = 1'b0;
    logic       data_in_ack;
    logic [7:0] data_out;
    logic       data_out_sop;
    logic       data_out_req;
    logic       data_out_ack = 1'b1;
    logic       locked;
    logic       sync_err;
    logic [1:0] dbg_state;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         err_pulses = 0;
    int         sum_exp = 0;
    int         sum_act = 0;
    bit         bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_idx = 0;
    bit         prev_hold = 1'b0;
    logic [8:0] prev_word = 9'd0;

    zl_ts_sync_aligner dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_req  (data_in_req),
        .data_in_ack  (data_in_ack),
        .data_out     (data_out),
        .data_out_sop (data_out_sop),
        .data_out_req (data_out_req),
        .data_out_ack (data_out_ack),
        .locked       (locked),
        .sync_err     (sync_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fwd, input bit sop);
        bit acc;
        int t;
        if (fwd) begin
            exp_q.push_back({sop, b});
            sum_exp += int'(b);
        end
        data_in     = b;
        data_in_req = 1'b1;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 1000) begin
            @(negedge clk);
            acc = data_in_ack;
            @(posedge clk); #1;
            t++;
        end
        data_in_req = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: byte %0h not accepted within 1000 cycles", b);
        end
    endtask

    // Packet = sync byte then bytes (j + seed) for j = 1..187.
    task automatic send_pkt(input logic [7:0] sync, input int seed, input bit fwd_sync, input bit fwd_rest);
        send_byte(sync, fwd_sync, 1'b1);
        for (int j = 1; j < 188; j++) send_byte(8'(j + seed), fwd_rest, 1'b0);
    endtask

    task automatic drain(input string name);
        repeat (8) @(posedge clk);
        #1;
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_data"}, 32'(data_out), 32'd0);
        check({name, "_sop"}, 32'(data_out_sop), 32'd0);
        check({name, "_req"}, 32'(data_out_req), 32'd0);
        check({name, "_locked"}, 32'(locked), 32'd0);
        check({name, "_sync_err"}, 32'(sync_err), 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    // ---------------- downstream ack driver ----------------
    always begin
        @(posedge clk); #1;
        if (bp_en) begin
            data_out_ack = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end else begin
            data_out_ack = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (sync_err) err_pulses++;
        if (prev_hold) begin
            check("hold_req", 32'(data_out_req), 32'd1);
            check("hold_word", 32'({data_out_sop, data_out}), 32'(prev_word));
        end
        if (locked && data_out_req && !data_out_ack)
            check("in_ack_blocked", 32'(data_in_ack), 32'd0);
        if (data_out_req && data_out_ack) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out: got sop=%0b data=%0h expected nothing", data_out_sop, data_out);
            end else begin
                e = exp_q.pop_front();
                check("out_word", 32'({data_out_sop, data_out}), 32'(e));
                sum_act += int'(data_out);
            end
        end
        prev_hold = data_out_req && !data_out_ack && !rst;
        prev_word = {data_out_sop, data_out};
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Clean stream: syncs 2..4 confirm, lock on packet 4's sync, which is forwarded.
        err_pulses = 0;
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, 1'b0, 1'b0);
        check("clean_locked_before", 32'(locked), 32'd0);
        check("clean_state_verify", 32'(dbg_state), 32'd1);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        check("clean_locked", 32'(locked), 32'd1);
        drain("clean");
        check("clean_no_sync_err", 32'(err_pulses), 32'd0);

        // Misalignment: 37 junk bytes (never 0x47) ahead of clean packets.
        do_reset();
        for (int i = 0; i < 37; i++) send_byte(8'(i * 3 + 1), 1'b0, 1'b0);
        check("mis_state_search", 32'(dbg_state), 32'd0);
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, 1'b0, 1'b0);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        check("mis_locked", 32'(locked), 32'd1);
        drain("mis");

        // False sync: 0x47 at index 5, 0x00 at index 193 (188 later).
        do_reset();
        for (int i = 0; i < 250; i++) begin
            logic [7:0] b;
            b = 8'(i);
            if (i == 5) b = 8'h47;
            else if (i == 193) b = 8'h00;
            else if (b == 8'h47) b = 8'h48;
            send_byte(b, 1'b0, 1'b0);
            if (i == 5) check("false_enter_verify", 32'(dbg_state), 32'd1);
            if (i == 193) check("false_back_search", 32'(dbg_state), 32'd0);
        end
        check("false_locked", 32'(locked), 32'd0);
        drain("false");

        // Loss of lock: three bad syncs while locked.
        do_reset();
        err_pulses = 0;
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, 1'b0, 1'b0);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        send_byte(8'h00, 1'b1, 1'b1);
        check("loss1_sync_err", 32'(sync_err), 32'd1);
        for (int j = 1; j < 188; j++) send_byte(8'(j), 1'b1, 1'b0);
        send_pkt(8'h00, 0, 1'b1, 1'b1);
        check("loss2_still_locked", 32'(locked), 32'd1);
        send_byte(8'h00, 1'b0, 1'b1);
        check("loss3_sync_err", 32'(sync_err), 32'd1);
        check("loss3_locked_fell", 32'(locked), 32'd0);
        for (int j = 1; j < 188; j++) send_byte(8'(j), 1'b0, 1'b0);
        check("loss_locked", 32'(locked), 32'd0);
        drain("loss");
        check("loss_err_pulses", 32'(err_pulses), 32'd3);

        // Backpressure: ack pattern 1,0,0,1; ten packets forwarded with checksum.
        do_reset();
        bp_en   = 1'b1;
        sum_exp = 0;
        sum_act = 0;
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, 1'b0, 1'b0);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        for (int p = 1; p < 10; p++) send_pkt(8'h47, p * 7, 1'b1, 1'b1);
        check("bp_locked", 32'(locked), 32'd1);
        bp_en = 1'b0;
        drain("bp");
        check("bp_checksum", 32'(sum_act), 32'(sum_exp));

        // Reset mid-packet at pos 90 while locked, then relock from scratch.
        do_reset();
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, 1'b0, 1'b0);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        send_byte(8'h47, 1'b1, 1'b1);
        for (int j = 1; j < 90; j++) send_byte(8'(j), 1'b1, 1'b0);
        check("mid_locked_before", 32'(locked), 32'd1);
        do_reset();
        check_outputs_zero("mid_reset");
        for (int j = 90; j < 188; j++) send_byte(8'(j), 1'b0, 1'b0);
        for (int p = 0; p < 3; p++) send_pkt(8'h47, 0, 1'b0, 1'b0);
        check("mid_not_yet_locked", 32'(locked), 32'd0);
        send_pkt(8'h47, 0, 1'b1, 1'b1);
        check("mid_relocked", 32'(locked), 32'd1);
        drain("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
